// File: rtl/control_unit_mc.sv
// Multi-cycle control FSM for Instruction_FD: fetch/decode/execute sequencing
// with registered instruction class and a retired-instruction counter.
module control_unit_mc #(
  parameter int LOAD_WAIT_CYCLES = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  output logic             WE_mem,
  output logic             WE_reg,
  output logic [1:0]       OP_MEM_I,
  output logic             ADD_SUB,
  output logic             PC_load,
  output logic             IR_load,
  output logic [2:0]       select_flags,
  output logic             JAL,
  output logic             JALR,
  output logic             AUIPC,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MWAIT, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_LOAD, C_STORE, C_ADDI,
    C_BR, C_JAL, C_JALR, C_AUIPC
  } cls_e;

  localparam logic [3:0] WAIT_INIT =
    4'(LOAD_WAIT_CYCLES - 1);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls;
  logic [2:0]       f3_q, f3_d;
  logic             f7_q, f7_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  // Legality of funct3 is resolved here so DECODE can branch to HALT.
  always_comb begin
    dec_cls = C_NONE;
    case (opcode)
      7'b0110011:
        if (funct3 == 3'b000) dec_cls = C_R;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b0010011:
        if (funct3 == 3'b000) dec_cls = C_ADDI;
      7'b1100011:
        if (funct3 != 3'b010 && funct3 != 3'b011)
          dec_cls = C_BR;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b0010111: dec_cls = C_AUIPC;
      default:    dec_cls = C_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
      f3_q    <= 3'b000;
      f7_q    <= 1'b0;
      cnt_q   <= 4'd0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        cls_d   = dec_cls;
        f3_d    = funct3;
        f7_d    = funct7_5;
        state_d = (dec_cls == C_NONE) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (cls_q == C_LOAD) begin
          state_d = S_MWAIT;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MWAIT: begin
        if (cnt_q == 4'd0) state_d = S_WB;
        else cnt_d = cnt_q - 4'd1;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    ret_d = PC_load ? ret_q + 1'b1 : ret_q;
  end

  always_comb begin
    WE_mem       = 1'b0;
    WE_reg       = 1'b0;
    OP_MEM_I     = 2'd0;
    ADD_SUB      = 1'b0;
    PC_load      = 1'b0;
    IR_load      = 1'b0;
    select_flags = 3'b010;
    JAL          = 1'b0;
    JALR         = 1'b0;
    AUIPC        = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_FETCH: IR_load = 1'b1;
      S_EXEC: begin
        case (cls_q)
          C_R: begin
            ADD_SUB = f7_q;
            WE_reg  = 1'b1;
            PC_load = 1'b1;
          end
          C_ADDI: begin
            OP_MEM_I = 2'd2;
            WE_reg   = 1'b1;
            PC_load  = 1'b1;
          end
          C_STORE: begin
            OP_MEM_I = 2'd1;
            WE_mem   = 1'b1;
            PC_load  = 1'b1;
          end
          C_BR: begin
            ADD_SUB      = 1'b1;
            select_flags = f3_q;
            PC_load      = 1'b1;
          end
          C_JAL: begin
            OP_MEM_I = 2'd3;
            JAL      = 1'b1;
            WE_reg   = 1'b1;
            PC_load  = 1'b1;
          end
          C_JALR: begin
            OP_MEM_I = 2'd3;
            JALR     = 1'b1;
            WE_reg   = 1'b1;
            PC_load  = 1'b1;
          end
          C_AUIPC: begin
            OP_MEM_I = 2'd3;
            AUIPC    = 1'b1;
            WE_reg   = 1'b1;
            PC_load  = 1'b1;
          end
          C_LOAD:  OP_MEM_I = 2'd1;
          default: OP_MEM_I = 2'd0;
        endcase
      end
      S_MWAIT: OP_MEM_I = 2'd1;
      S_WB: begin
        OP_MEM_I = 2'd1;
        WE_reg   = 1'b1;
        PC_load  = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  assign retired = ret_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: vector table for execute decode,
// hand sequences for load, halt, async reset and a 3-cycle load wait.
module tb_control_unit_mc;

  logic        clk = 1'b0;
  logic        reset, rst3;
  logic [6:0]  opcode, opcode3;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        we_mem, we_reg, add_sub, pc_load, ir_load;
  logic        jal, jalr, auipc, halted;
  logic [1:0]  op_mem_i;
  logic [2:0]  sel;
  logic [31:0] retired;
  logic        we_mem3, we_reg3, add_sub3, pc_load3, ir_load3;
  logic        jal3, jalr3, auipc3, halted3;
  logic [1:0]  op_mem_i3;
  logic [2:0]  sel3;
  logic [31:0] retired3;

  int tests = 0;
  int fails = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  control_unit_mc #(.LOAD_WAIT_CYCLES(1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .funct3(funct3), .funct7_5(funct7_5),
    .WE_mem(we_mem), .WE_reg(we_reg), .OP_MEM_I(op_mem_i),
    .ADD_SUB(add_sub), .PC_load(pc_load), .IR_load(ir_load),
    .select_flags(sel), .JAL(jal), .JALR(jalr), .AUIPC(auipc),
    .halted(halted), .retired(retired)
  );

  control_unit_mc #(.LOAD_WAIT_CYCLES(3), .CNT_W(32)) dut3 (
    .clk(clk), .reset(rst3), .opcode(opcode3),
    .funct3(3'b010), .funct7_5(1'b0),
    .WE_mem(we_mem3), .WE_reg(we_reg3), .OP_MEM_I(op_mem_i3),
    .ADD_SUB(add_sub3), .PC_load(pc_load3), .IR_load(ir_load3),
    .select_flags(sel3), .JAL(jal3), .JALR(jalr3), .AUIPC(auipc3),
    .halted(halted3), .retired(retired3)
  );

  wire [13:0] obus = {we_mem, we_reg, op_mem_i, add_sub, pc_load,
                      ir_load, sel, jal, jalr, auipc, halted};

  function automatic logic [13:0] mk(
    input logic wm, input logic wr, input logic [1:0] op,
    input logic as, input logic pc, input logic ir,
    input logic [2:0] sl, input logic j, input logic jr,
    input logic au, input logic h);
    return {wm, wr, op, as, pc, ir, sl, j, jr, au, h};
  endfunction

  localparam logic [13:0] DEF = 14'b0_0_00_0_0_0_010_0_0_0_0;
  localparam logic [13:0] FET = 14'b0_0_00_0_0_1_010_0_0_0_0;
  localparam logic [13:0] HLT = 14'b0_0_00_0_0_0_010_0_0_0_1;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [13:0] ex;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_halt(input string nm);
    step();
    chk({nm, "_decode"}, 32'(obus), 32'(DEF));
    step();
    chk({nm, "_halt"}, 32'(obus), 32'(HLT));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{7'b0110011, 3'b000, 1'b1, mk(0,1,0,1,1,0,2,0,0,0,0)};
    vt[1]  = '{7'b0110011, 3'b000, 1'b0, mk(0,1,0,0,1,0,2,0,0,0,0)};
    vt[2]  = '{7'b0100011, 3'b010, 1'b0, mk(1,0,1,0,1,0,2,0,0,0,0)};
    vt[3]  = '{7'b0010011, 3'b000, 1'b0, mk(0,1,2,0,1,0,2,0,0,0,0)};
    vt[4]  = '{7'b0010011, 3'b000, 1'b1, mk(0,1,2,0,1,0,2,0,0,0,0)};
    vt[5]  = '{7'b1100011, 3'b001, 1'b0, mk(0,0,0,1,1,0,1,0,0,0,0)};
    vt[6]  = '{7'b1100011, 3'b000, 1'b0, mk(0,0,0,1,1,0,0,0,0,0,0)};
    vt[7]  = '{7'b1100011, 3'b111, 1'b1, mk(0,0,0,1,1,0,7,0,0,0,0)};
    vt[8]  = '{7'b1101111, 3'b101, 1'b0, mk(0,1,3,0,1,0,2,1,0,0,0)};
    vt[9]  = '{7'b1100111, 3'b000, 1'b0, mk(0,1,3,0,1,0,2,0,1,0,0)};
    vt[10] = '{7'b0010111, 3'b110, 1'b1, mk(0,1,3,0,1,0,2,0,0,1,0)};

    reset = 1'b1;
    rst3 = 1'b1;
    opcode = 7'h00;
    opcode3 = 7'b0000011;
    funct3 = 3'b000;
    funct7_5 = 1'b0;
    #16 reset = 1'b0;
    #1;
    chk("idle_outputs", 32'(obus), 32'(DEF));
    chk("idle_retired", retired, 32'd0);
    step();
    chk("fetch_first", 32'(obus), 32'(FET));

    for (int i = 0; i < 11; i++) begin
      opcode = vt[i].op;
      funct3 = vt[i].f3;
      funct7_5 = vt[i].f7;
      step();
      chk($sformatf("v%0d_decode", i), 32'(obus), 32'(DEF));
      step();
      opcode = 7'h7F;
      funct3 = 3'b011;
      funct7_5 = ~vt[i].f7;
      #1;
      chk($sformatf("v%0d_exec", i), 32'(obus), 32'(vt[i].ex));
      step();
      exp_ret++;
      chk($sformatf("v%0d_fetch", i), 32'(obus), 32'(FET));
      chk($sformatf("v%0d_retired", i), retired, 32'(exp_ret));
    end

    opcode = 7'b0000011;
    funct3 = 3'b010;
    step();
    chk("ld_decode", 32'(obus), 32'(DEF));
    step();
    chk("ld_exec", 32'(obus), 32'(mk(0,0,1,0,0,0,2,0,0,0,0)));
    step();
    chk("ld_mwait", 32'(obus), 32'(mk(0,0,1,0,0,0,2,0,0,0,0)));
    chk("ld_mwait_ret", retired, 32'(exp_ret));
    step();
    chk("ld_wb", 32'(obus), 32'(mk(0,1,1,0,1,0,2,0,0,0,0)));
    step();
    exp_ret++;
    chk("ld_fetch", 32'(obus), 32'(FET));
    chk("ld_retired", retired, 32'(exp_ret));

    opcode = 7'b0110011;
    funct3 = 3'b001;
    run_to_halt("r_f3_001");
    for (int k = 0; k < 20; k++) begin
      opcode = 7'(k * 13);
      step();
      chk($sformatf("halt_hold%0d", k), 32'(obus), 32'(HLT));
    end
    chk("halt_retired", retired, 32'(exp_ret));

    reset = 1'b1;
    #1;
    chk("halt_reset_out", 32'(obus), 32'(DEF));
    chk("halt_reset_ret", retired, 32'd0);
    exp_ret = 0;
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post_halt_fetch", 32'(obus), 32'(FET));

    opcode = 7'b1111111;
    funct3 = 3'b000;
    run_to_halt("op_7f");
    step();
    chk("op_7f_hold", 32'(obus), 32'(HLT));
    reset = 1'b1;
    #1;
    chk("op_7f_reset", 32'(obus), 32'(DEF));
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("op_7f_fetch", 32'(obus), 32'(FET));

    opcode = 7'b0010011;
    funct3 = 3'b000;
    step();
    step();
    step();
    chk("pre_rst_retired", retired, 32'd1);
    opcode = 7'b0110011;
    funct7_5 = 1'b1;
    step();
    step();
    chk("mid_exec", 32'(obus), 32'(mk(0,1,0,1,1,0,2,0,0,0,0)));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out", 32'(obus), 32'(DEF));
    chk("async_rst_ret", retired, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("async_rst_fetch", 32'(obus), 32'(FET));

    rst3 = 1'b0;
    step();
    chk("w3_fetch", 32'(ir_load3), 32'd1);
    begin
      int lat;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
        if (pc_load3) begin
          lat = k;
          break;
        end
        if (k > 2)
          chk($sformatf("w3_op%0d", k), 32'(op_mem_i3), 32'd1);
        step();
      end
      chk("w3_latency", lat, 32'd7);
    end
    step();
    chk("w3_retired", retired3, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
